// File: rtl/prv32_branch_resolve.sv
// EX/MEM branch resolution for the 32-bit pipeline: decodes ALU flags into a branch
// condition, issues a registered fetch redirect, holds a counted flush and keeps branch stats.
//
// state | meaning
// IDLE  | ready to accept a valid EX instruction and resolve it
// FLUSH | redirect issued, squashing wrong-path instructions for FLUSH_CYCLES unstalled cycles
module prv32_branch_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_target,
    input  logic             cf,
    input  logic             zf,
    input  logic             vf,
    input  logic             sf,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state, state_nxt;
    logic [3:0]       fcnt, fcnt_nxt;
    logic             redirect_valid_nxt, flush_nxt, busy_nxt;
    logic [31:0]      redirect_pc_nxt;
    logic [CNT_W-1:0] branch_cnt_nxt, taken_cnt_nxt;

    logic cond, legal, accept, taken, count_br;

    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:  cond = zf;
            3'b001:  cond = !zf;
            3'b100:  cond = (sf != vf);
            3'b101:  cond = (sf == vf);
            3'b110:  cond = !cf;
            3'b111:  cond = cf;
            default: cond = 1'b0;
        endcase
    end

    assign legal    = (ex_funct3[2:1] != 2'b01);
    assign accept   = ex_valid && !stall && (state == IDLE);
    assign taken    = accept && (ex_jump || (ex_branch && cond));
    assign count_br = accept && ex_branch && !ex_jump && legal;

    always_comb begin
        state_nxt          = state;
        fcnt_nxt           = fcnt;
        redirect_valid_nxt = redirect_valid;
        redirect_pc_nxt    = redirect_pc;
        flush_nxt          = flush;
        busy_nxt           = busy;
        branch_cnt_nxt     = branch_cnt;
        taken_cnt_nxt      = taken_cnt;

        // the redirect pulse only retires once fetch has actually seen an unstalled edge
        if (!stall) begin
            redirect_valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (taken) begin
                    state_nxt          = FLUSH;
                    redirect_valid_nxt = 1'b1;
                    redirect_pc_nxt    = ex_target;
                    flush_nxt          = 1'b1;
                    busy_nxt           = 1'b1;
                    fcnt_nxt           = FLUSH_INIT;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    fcnt_nxt = fcnt - 4'd1;
                    if (fcnt == 4'd1) begin
                        state_nxt = IDLE;
                        flush_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (count_br && (branch_cnt != CNT_MAX)) begin
            branch_cnt_nxt = branch_cnt + 1'b1;
        end
        if (count_br && cond && (taken_cnt != CNT_MAX)) begin
            taken_cnt_nxt = taken_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            fcnt           <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            busy           <= 1'b0;
            branch_cnt     <= '0;
            taken_cnt      <= '0;
        end else begin
            state          <= state_nxt;
            fcnt           <= fcnt_nxt;
            redirect_valid <= redirect_valid_nxt;
            redirect_pc    <= redirect_pc_nxt;
            flush          <= flush_nxt;
            busy           <= busy_nxt;
            branch_cnt     <= branch_cnt_nxt;
            taken_cnt      <= taken_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_prv32_branch_resolve.sv
// Directed bench for prv32_branch_resolve: default instance plus a CNT_W=2 instance
// for counter saturation; both share the same stimulus.
module tb_prv32_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, ex_valid, ex_branch, ex_jump;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_target;
    logic        cf, zf, vf, sf;

    logic        redirect_valid, flush, busy;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, taken_cnt;

    logic        s_redirect_valid, s_flush, s_busy;
    logic [31:0] s_redirect_pc;
    logic [1:0]  s_branch_cnt, s_taken_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prv32_branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_funct3(ex_funct3), .ex_target(ex_target),
        .cf(cf), .zf(zf), .vf(vf), .sf(sf),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .busy(busy), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    prv32_branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_funct3(ex_funct3), .ex_target(ex_target),
        .cf(cf), .zf(zf), .vf(vf), .sf(sf),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .flush(s_flush),
        .busy(s_busy), .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic jmp, input logic [2:0] f3,
                         input logic c, input logic z, input logic v, input logic s,
                         input logic [31:0] tgt);
        ex_valid  = 1'b1;
        ex_branch = br;
        ex_jump   = jmp;
        ex_funct3 = f3;
        cf = c; zf = z; vf = v; sf = s;
        ex_target = tgt;
    endtask

    task automatic idle();
        ex_valid  = 1'b0;
        ex_branch = 1'b0;
        ex_jump   = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic rv, input logic fl, input logic bz);
        chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        chk({tag, ".flush"},          32'(flush),          32'(fl));
        chk({tag, ".busy"},           32'(busy),           32'(bz));
    endtask

    task automatic chk_cnt(input string tag, input int bc, input int tc);
        chk({tag, ".branch_cnt"}, 32'(branch_cnt), 32'(bc));
        chk({tag, ".taken_cnt"},  32'(taken_cnt),  32'(tc));
    endtask

    // one taken instruction then let both flush cycles retire
    task automatic branch_and_drain(input logic br, input logic jmp, input logic [2:0] f3,
                                    input logic c, input logic z, input logic v, input logic s,
                                    input logic [31:0] tgt);
        drive(br, jmp, f3, c, z, v, s, tgt);
        step();
        idle();
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        idle();
        ex_funct3 = 3'b000;
        ex_target = '0;
        {cf, zf, vf, sf} = '0;
        step();
        chk_out("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.redirect_pc", redirect_pc, 32'h0);
        chk_cnt("reset", 0, 0);
        rst = 1'b0;

        // BEQ taken: pulse then two flush cycles
        drive(1, 0, 3'b000, 0, 1, 0, 0, 32'h0000_0100);
        step();
        idle();
        chk_out("beq.n1", 1, 1, 1);
        chk("beq.n1.redirect_pc", redirect_pc, 32'h100);
        step();
        chk_out("beq.n2", 0, 1, 1);
        step();
        chk_out("beq.n3", 0, 0, 0);
        chk_cnt("beq", 1, 1);

        // BLTU cf=1 not taken, then cf=0 taken
        drive(1, 0, 3'b110, 1, 0, 0, 0, 32'h0000_0180);
        step();
        idle();
        chk_out("bltu_nt", 0, 0, 0);
        chk("bltu_nt.redirect_pc", redirect_pc, 32'h100);
        chk_cnt("bltu_nt", 2, 1);
        drive(1, 0, 3'b110, 0, 0, 0, 0, 32'h0000_0184);
        step();
        idle();
        chk_out("bltu_t", 1, 1, 1);
        chk("bltu_t.redirect_pc", redirect_pc, 32'h184);
        step();
        step();
        chk_cnt("bltu_t", 3, 2);

        // BLT sf!=vf taken
        branch_and_drain(1, 0, 3'b100, 0, 0, 0, 1, 32'h0000_0188);
        chk("blt_t.redirect_pc", redirect_pc, 32'h188);
        chk_cnt("blt_t", 4, 3);
        // BLT sf==vf not taken
        drive(1, 0, 3'b100, 0, 0, 1, 1, 32'h0000_018c);
        step();
        idle();
        chk_out("blt_nt", 0, 0, 0);
        // BGE sf!=vf not taken
        drive(1, 0, 3'b101, 0, 0, 1, 0, 32'h0000_0190);
        step();
        idle();
        chk_out("bge_nt", 0, 0, 0);
        chk_cnt("bge_nt", 6, 3);

        // JAL, then a taken BNE presented through both flush cycles
        drive(0, 1, 3'b000, 0, 1, 0, 0, 32'h0000_0200);
        step();
        chk_out("jal.n1", 1, 1, 1);
        chk("jal.n1.redirect_pc", redirect_pc, 32'h200);
        drive(1, 0, 3'b001, 0, 0, 0, 0, 32'h0000_0300);
        step();
        chk_out("squash.n2", 0, 1, 1);
        chk("squash.n2.redirect_pc", redirect_pc, 32'h200);
        step();
        idle();
        chk_out("squash.n3", 0, 0, 0);
        chk("squash.n3.redirect_pc", redirect_pc, 32'h200);
        chk_cnt("squash", 6, 3);

        // stall in IDLE accepts nothing
        stall = 1'b1;
        drive(1, 0, 3'b000, 0, 1, 0, 0, 32'h0000_0380);
        step();
        idle();
        stall = 1'b0;
        chk_out("idle_stall", 0, 0, 0);
        chk_cnt("idle_stall", 6, 3);

        // stall for 3 cycles in the first flush cycle
        drive(1, 0, 3'b000, 0, 1, 0, 0, 32'h0000_0400);
        step();
        idle();
        chk_out("stall.n1", 1, 1, 1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("stall.hold%0d", i), 1, 1, 1);
        end
        stall = 1'b0;
        step();
        chk_out("stall.rel1", 0, 1, 1);
        step();
        chk_out("stall.rel2", 0, 0, 0);
        chk_cnt("stall", 7, 4);

        // asynchronous reset in the middle of a flush
        drive(1, 0, 3'b000, 0, 1, 0, 0, 32'h0000_0500);
        step();
        idle();
        chk_out("rstmid.n1", 1, 1, 1);
        #2 rst = 1'b1;
        #1;
        chk_out("rstmid.async", 0, 0, 0);
        chk("rstmid.redirect_pc", redirect_pc, 32'h0);
        chk_cnt("rstmid", 0, 0);
        #1 rst = 1'b0;
        drive(1, 0, 3'b000, 0, 1, 0, 0, 32'h0000_0600);
        step();
        idle();
        chk_out("post_rst.n1", 1, 1, 1);
        chk("post_rst.redirect_pc", redirect_pc, 32'h600);
        step();
        step();
        chk_out("post_rst.n3", 0, 0, 0);
        chk_cnt("post_rst", 1, 1);

        // saturation on the narrow instance
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            branch_and_drain(1, 0, 3'b000, 0, 1, 0, 0, 32'h0000_0700 + 32'(i * 4));
        end
        chk("sat.branch_cnt", 32'(s_branch_cnt), 32'd3);
        chk("sat.taken_cnt",  32'(s_taken_cnt),  32'd3);
        chk_cnt("wide5", 5, 5);
        chk("sat.redirect_pc", s_redirect_pc, 32'h710);

        // illegal funct3 with zf=1: not taken, not counted
        drive(1, 0, 3'b010, 0, 1, 0, 0, 32'h0000_0800);
        step();
        idle();
        chk_out("illegal", 0, 0, 0);
        chk_cnt("illegal", 5, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prv32_branch_resolve.md
Name: prv32_branch_resolve

Overview:
- Consumer end of the ALU flag interface: takes the cf/zf/vf/sf flags the ALU produces for the SUB of the two branch operands, plus EX-stage control.
- Resolves conditional branches and jumps, issues a registered PC redirect to fetch, and drives a counted flush of wrong-path younger instructions.
- Sits at the EX/MEM boundary of the 32-bit pipeline. Also keeps saturating branch/taken statistics counters.

Parameters:
FLUSH_CYCLES, 2, cycles flush is held after a taken redirect (legal range 1..15; 0 illegal)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
stall  in  1  pipeline stall; freezes all state except redirect hold rule
ex_valid  in  1  EX stage holds a valid instruction
ex_branch  in  1  instruction is a conditional branch
ex_jump  in  1  instruction is JAL/JALR (unconditional)
ex_funct3  in  3  branch funct3
ex_target  in  32  computed target PC
cf  in  1  ALU carry out of a+~b+1 (1 means a>=b unsigned)
zf  in  1  ALU zero flag
vf  in  1  ALU overflow flag
sf  in  1  ALU sign flag
redirect_valid  out  1  fetch must load redirect_pc
redirect_pc  out  32  redirect target
flush  out  1  squash IF/ID/EX contents
busy  out  1  FSM in FLUSH
branch_cnt  out  CNT_W  accepted conditional branches
taken_cnt  out  CNT_W  accepted taken conditional branches

Behaviour:
- Reset (async, immediate, including mid-flush): state=IDLE, redirect_valid=0, redirect_pc=0, flush=0, busy=0, both counters=0, flush counter=0.
- Condition decode from flags:
  - 000 BEQ: zf
  - 001 BNE: !zf
  - 100 BLT: sf!=vf
  - 101 BGE: sf==vf
  - 110 BLTU: !cf
  - 111 BGEU: cf
  - 010/011: illegal, never taken, not counted
- Accept: accept = ex_valid & !stall & state==IDLE.
- Taken: taken = accept & (ex_jump | (ex_branch & cond)). ex_jump has priority over ex_branch; a jump is never counted.
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH on taken at the clock edge. At that edge: redirect_valid<=1, redirect_pc<=ex_target, flush<=1, busy<=1, fcnt<=FLUSH_CYCLES.
  - Latency: branch in EX in cycle N -> redirect_valid and flush visible in cycle N+1.
- redirect_valid hold: stays 1 until the first edge with stall=0 after it is set, then clears. It is a single-cycle pulse when there is no stall.
- FLUSH state:
  - flush=1 and ex_valid is ignored: no accept, no counting, no new redirect.
  - Each edge with stall=0 decrements fcnt.
  - On an edge with stall=0 and fcnt==1: state->IDLE, flush<=0, busy<=0.
  - stall=1 freezes fcnt, so flush lasts exactly FLUSH_CYCLES non-stalled cycles.
- Not taken: accepted non-taken instructions leave all outputs unchanged and the FSM in IDLE.
- Counters:
  - branch_cnt +1 on accept & ex_branch & !ex_jump & legal funct3.
  - taken_cnt +1 when such a branch is taken.
  - Both saturate at all-ones and never wrap.
- No redirect is issued while in FLUSH. A second taken instruction can only be accepted from IDLE, so back-to-back taken instructions are separated by at least FLUSH_CYCLES+1 cycles.
- stall=1 in IDLE: nothing is accepted and state holds.

Test Plan:
- BEQ taken: ex_valid=1, ex_branch=1, funct3=000, zf=1, target=0x0000_0100, FLUSH_CYCLES=2 -> cycle N+1: redirect_valid=1, redirect_pc=0x100, flush=1. Cycle N+2: redirect_valid=0, flush=1. Cycle N+3: flush=0, busy=0. branch_cnt=1, taken_cnt=1.
- Unsigned/signed conditions: BLTU with cf=1 -> no redirect; cf=0 -> taken. BLT with sf=1,vf=0 -> taken; sf=1,vf=1 -> not taken. BGE with sf=0,vf=1 -> not taken. Each accepted branch increments branch_cnt; taken_cnt equals the number taken.
- Flush squash: taken JAL, target 0x200, then ex_valid=1 with a taken BNE during both flush cycles -> no second redirect, counters unchanged, jump not counted.
- Stall extension: taken branch, then stall=1 for 3 cycles in the first flush cycle -> redirect_valid and flush held through the stall; flush deasserts 2 non-stalled cycles later.
- Reset mid-flush: assert rst asynchronously in cycle N+1 -> flush, redirect_valid, busy and counters go to 0 immediately without a clock edge; after release, the next taken branch works normally.
- Saturation and illegal funct3: CNT_W=2, 5 taken BEQs -> branch_cnt=3, taken_cnt=3. funct3=010 with zf=1 -> not taken, not counted.
